// File: rtl/unpool_upsample_1_pkg.sv
// Shared definitions for the 2x nearest-neighbour unpool/upsample block.
//   DATA_BIT        per-channel sample width
//   HALF_WIDTH      pooled frame width (input samples per row)
//   HALF_HEIGHT     pooled frame height (input rows per frame)
//   HALF_WIDTH_BIT  input column counter width
//   state_e         control FSM encoding
package cnn_pkg;

  localparam int DATA_BIT       = 12;
  localparam int HALF_WIDTH     = 12;
  localparam int HALF_HEIGHT    = 12;
  localparam int HALF_WIDTH_BIT = 4;

  // Output column runs over 2*HALF_WIDTH positions, so one extra bit.
  localparam int OUT_COL_BIT    = HALF_WIDTH_BIT + 1;
  localparam int ROW_CNT_BIT    = $clog2(HALF_HEIGHT);
  // Three channels are stored side by side in one buffer word.
  localparam int PIX_BIT        = 3 * DATA_BIT;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    EMIT_A = 2'd1,
    EMIT_B = 2'd2
  } state_e;

endpackage

// File: rtl/unpool_upsample_1_if.sv
// Stream interface of the upsampler.
//   valid_in/ready_in/data_in_1..3     upstream pooled samples
//   valid_out/ready_out/data_out_1..3  downstream upsampled samples
//   frame_done                         one-cycle end-of-frame pulse
// master: the environment (source + sink); slave: the upsampler.
interface unpool_upsample_1_if;
  import cnn_pkg::*;

  logic                valid_in;
  logic                ready_in;
  logic [DATA_BIT-1:0] data_in_1;
  logic [DATA_BIT-1:0] data_in_2;
  logic [DATA_BIT-1:0] data_in_3;
  logic                valid_out;
  logic                ready_out;
  logic [DATA_BIT-1:0] data_out_1;
  logic [DATA_BIT-1:0] data_out_2;
  logic [DATA_BIT-1:0] data_out_3;
  logic                frame_done;

  modport master (
    output valid_in, data_in_1, data_in_2, data_in_3, ready_out,
    input  ready_in, valid_out, data_out_1, data_out_2, data_out_3, frame_done
  );

  modport slave (
    input  valid_in, data_in_1, data_in_2, data_in_3, ready_out,
    output ready_in, valid_out, data_out_1, data_out_2, data_out_3, frame_done
  );

endinterface

// File: rtl/unpool_upsample_1_line_buf.sv
// Row buffer holding one pooled row (all three channels per word).
//   clk    write clock
//   we     write enable
//   waddr  write column
//   wdata  packed {ch3, ch2, ch1} sample
//   raddr  read column (asynchronous read)
//   rdata  packed sample at raddr
// Contents are deliberately not reset.
module upsample_line_buf #(
  parameter int DEPTH    = 12,
  parameter int WIDTH    = 36,
  parameter int ADDR_BIT = 4
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_BIT-1:0] waddr,
  input  logic [WIDTH-1:0]    wdata,
  input  logic [ADDR_BIT-1:0] raddr,
  output logic [WIDTH-1:0]    rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/unpool_upsample_1.sv
// 2x nearest-neighbour upsampler. Buffers one pooled row in LOAD, then
// replays it twice (EMIT_A, EMIT_B), each output column k carrying
// buffer[k>>1], giving a 2*HALF_WIDTH x 2*HALF_HEIGHT raster stream.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    stream interface (slave view), see unpool_upsample_1_if
module unpool_upsample_1
  import cnn_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  unpool_upsample_1_if.slave  bus
);

  localparam logic [HALF_WIDTH_BIT-1:0] COL_IN_LAST  = HALF_WIDTH_BIT'(HALF_WIDTH - 1);
  localparam logic [OUT_COL_BIT-1:0]    OUT_COL_LAST = OUT_COL_BIT'(2 * HALF_WIDTH - 1);
  localparam logic [ROW_CNT_BIT-1:0]    ROW_LAST     = ROW_CNT_BIT'(HALF_HEIGHT - 1);

  state_e                    state_q, state_d;
  logic [HALF_WIDTH_BIT-1:0] col_in_q, col_in_d;
  logic [OUT_COL_BIT-1:0]    out_col_q, out_col_d;
  logic [ROW_CNT_BIT-1:0]    row_cnt_q, row_cnt_d;
  logic                      valid_out_q, valid_out_d;
  logic                      frame_done_q, frame_done_d;
  logic [PIX_BIT-1:0]        data_out_q, data_out_d;

  logic                      in_xfer;
  logic                      out_xfer;
  logic                      load_out;
  logic                      buf_we;
  logic [HALF_WIDTH_BIT-1:0] rd_addr;
  logic [PIX_BIT-1:0]        rd_data;
  logic [PIX_BIT-1:0]        wr_data;

  assign in_xfer  = (state_q == LOAD) && bus.valid_in;
  assign out_xfer = valid_out_q && bus.ready_out;
  assign wr_data  = {bus.data_in_3, bus.data_in_2, bus.data_in_1};

  upsample_line_buf #(
    .DEPTH    (HALF_WIDTH),
    .WIDTH    (PIX_BIT),
    .ADDR_BIT (HALF_WIDTH_BIT)
  ) u_line_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (col_in_q),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    col_in_d     = col_in_q;
    out_col_d    = out_col_q;
    row_cnt_d    = row_cnt_q;
    valid_out_d  = valid_out_q;
    frame_done_d = 1'b0;
    buf_we       = 1'b0;
    load_out     = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_xfer) begin
          buf_we = 1'b1;
          if (col_in_q == COL_IN_LAST) begin
            // The last column is written on this edge; column 0 (already
            // stored) is presented at the same time, so valid follows
            // the final input by one cycle.
            col_in_d    = '0;
            state_d     = EMIT_A;
            valid_out_d = 1'b1;
            load_out    = 1'b1;
          end else begin
            col_in_d = col_in_q + 1'b1;
          end
        end
      end
      EMIT_A, EMIT_B: begin
        if (out_xfer) begin
          if (out_col_q == OUT_COL_LAST) begin
            out_col_d = '0;
            if (state_q == EMIT_A) begin
              state_d  = EMIT_B;
              load_out = 1'b1;
            end else begin
              state_d     = LOAD;
              valid_out_d = 1'b0;
              if (row_cnt_q == ROW_LAST) begin
                row_cnt_d    = '0;
                frame_done_d = 1'b1;
              end else begin
                row_cnt_d = row_cnt_q + 1'b1;
              end
            end
          end else begin
            out_col_d = out_col_q + 1'b1;
            load_out  = 1'b1;
          end
        end
      end
      default: begin
        state_d     = LOAD;
        valid_out_d = 1'b0;
      end
    endcase
  end

  // Pre-fetch the sample for the next output column (nearest neighbour).
  assign rd_addr = out_col_d[OUT_COL_BIT-1:1];

  always_comb begin
    data_out_d = data_out_q;
    if (load_out) begin
      data_out_d = rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      col_in_q     <= '0;
      out_col_q    <= '0;
      row_cnt_q    <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      col_in_q     <= col_in_d;
      out_col_q    <= out_col_d;
      row_cnt_q    <= row_cnt_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
      data_out_q   <= data_out_d;
    end
  end

  assign bus.ready_in   = (state_q == LOAD);
  assign bus.valid_out  = valid_out_q;
  assign bus.frame_done = frame_done_q;
  assign bus.data_out_1 = data_out_q[DATA_BIT-1:0];
  assign bus.data_out_2 = data_out_q[2*DATA_BIT-1:DATA_BIT];
  assign bus.data_out_3 = data_out_q[PIX_BIT-1:2*DATA_BIT];

endmodule

// File: tb/tb_unpool_upsample_1.sv
// Directed bench for unpool_upsample_1: reset, latency, ramp frame,
// backpressure, ignored upstream valid, mid-frame reset, channel values.
module tb_unpool_upsample_1;
  import cnn_pkg::*;

  localparam int FRAME_OUT = 4 * HALF_WIDTH * HALF_HEIGHT;
  localparam int MAX_CYC   = 20000;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  unpool_upsample_1_if bus();

  unpool_upsample_1 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    bus.valid_in  = 1'b0;
    bus.data_in_1 = '0;
    bus.data_in_2 = '0;
    bus.data_in_3 = '0;
    bus.ready_out = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.valid_in  = 1'b1;
    bus.data_in_1 = 12'h123;
    bus.data_in_2 = 12'h456;
    bus.data_in_3 = 12'h789;
    bus.ready_out = 1'b1;
    apply_reset(2);
    checks++;
    if (bus.ready_in !== 1'b1) begin
      errors++; $display("FAIL reset_ready_in got %b want 1", bus.ready_in);
    end
    checks++;
    if (bus.valid_out !== 1'b0) begin
      errors++; $display("FAIL reset_valid_out got %b want 0", bus.valid_out);
    end
    checks++;
    if (bus.frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done);
    end
    checks++;
    if ({bus.data_out_3, bus.data_out_2, bus.data_out_1} !== 36'h0) begin
      errors++; $display("FAIL reset_data_out got %h want 0",
                         {bus.data_out_3, bus.data_out_2, bus.data_out_1});
    end
    drive_idle();
  endtask

  task automatic test_latency();
    bit early;
    logic [35:0] held;
    early = 1'b0;
    apply_reset(1);
    bus.ready_out = 1'b0;
    for (int c = 0; c < HALF_WIDTH; c++) begin
      if (bus.valid_out !== 1'b0) early = 1'b1;
      bus.valid_in  = 1'b1;
      bus.data_in_1 = 12'(12'h0A0 + c);
      bus.data_in_2 = 12'(12'h5A0 + c);
      bus.data_in_3 = 12'(12'h9A0 + c);
      @(posedge clk); #1;
    end
    bus.valid_in = 1'b0;
    checks++;
    if (early) begin
      errors++; $display("FAIL latency_early valid_out rose before 12th input");
    end
    checks++;
    if (bus.valid_out !== 1'b1) begin
      errors++; $display("FAIL latency_valid got %b want 1", bus.valid_out);
    end
    checks++;
    if (bus.ready_in !== 1'b0) begin
      errors++; $display("FAIL latency_ready_in got %b want 0", bus.ready_in);
    end
    held = {bus.data_out_3, bus.data_out_2, bus.data_out_1};
    checks++;
    if (held !== 36'h9A0_5A0_0A0) begin
      errors++; $display("FAIL latency_data got %h want 9a05a00a0", held);
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
    checks++;
    if (bus.valid_out !== 1'b1 ||
        {bus.data_out_3, bus.data_out_2, bus.data_out_1} !== held) begin
      errors++; $display("FAIL latency_hold got v=%b d=%h want v=1 d=%h", bus.valid_out,
                         {bus.data_out_3, bus.data_out_2, bus.data_out_1}, held);
    end
    drive_idle();
    apply_reset(1);
  endtask

  // Streams a frame (or its first total_out outputs) and checks every
  // output transfer against the nearest-neighbour expectation.
  task automatic run_frame(input int total_out, input bit bp, input bit spam,
                           input bit chconst, input string tag);
    int in_r, in_c, out_n, fd, cyc, y, x;
    bit stall_prev;
    logic [35:0] held, got, want;
    logic [11:0] v;
    in_r = 0; in_c = 0; out_n = 0; fd = 0; cyc = 0;
    stall_prev = 1'b0;
    held = '0;
    while (out_n < total_out && cyc < MAX_CYC) begin
      if (bus.frame_done === 1'b1) fd++;
      got = {bus.data_out_3, bus.data_out_2, bus.data_out_1};
      if (stall_prev) begin
        checks++;
        if (bus.valid_out !== 1'b1 || got !== held) begin
          errors++; $display("FAIL %s hold out %0d got v=%b d=%h want v=1 d=%h",
                             tag, out_n, bus.valid_out, got, held);
        end
      end
      if (spam && bus.valid_out === 1'b1) begin
        checks++;
        if (bus.ready_in !== 1'b0) begin
          errors++; $display("FAIL %s ready_in_emit got %b want 0", tag, bus.ready_in);
        end
      end
      if (bus.ready_in === 1'b1 && in_r < HALF_HEIGHT) begin
        bus.valid_in = 1'b1;
        if (chconst) begin
          bus.data_in_1 = 12'hFFF;
          bus.data_in_2 = 12'h000;
          bus.data_in_3 = 12'h800;
        end else begin
          v = 12'(16 * in_r + in_c);
          bus.data_in_1 = v;
          bus.data_in_2 = v;
          bus.data_in_3 = v;
        end
      end else if (spam) begin
        bus.valid_in  = 1'b1;
        bus.data_in_1 = 12'($urandom);
        bus.data_in_2 = 12'($urandom);
        bus.data_in_3 = 12'($urandom);
      end else begin
        bus.valid_in = 1'b0;
      end
      bus.ready_out = bp ? ((cyc % 2) == 0) : 1'b1;
      if (bus.valid_in === 1'b1 && bus.ready_in === 1'b1) begin
        if (in_c == HALF_WIDTH - 1) begin
          in_c = 0; in_r++;
        end else begin
          in_c++;
        end
      end
      if (bus.valid_out === 1'b1 && bus.ready_out === 1'b1) begin
        y = out_n / (2 * HALF_WIDTH);
        x = out_n % (2 * HALF_WIDTH);
        if (chconst) begin
          want = {12'h800, 12'h000, 12'hFFF};
        end else begin
          v = 12'(16 * (y >> 1) + (x >> 1));
          want = {v, v, v};
        end
        checks++;
        if (got !== want) begin
          errors++; $display("FAIL %s out %0d (y=%0d x=%0d) got %h want %h",
                             tag, out_n, y, x, got, want);
        end
        out_n++;
      end
      stall_prev = (bus.valid_out === 1'b1) && (bus.ready_out === 1'b0);
      held = got;
      @(posedge clk); #1;
      cyc++;
    end
    bus.valid_in = 1'b0;
    if (cyc >= MAX_CYC) begin
      checks++; errors++;
      $display("FAIL %s timeout outputs got %0d want %0d", tag, out_n, total_out);
    end
    checks++;
    if (fd !== 0) begin
      errors++; $display("FAIL %s early_frame_done got %0d pulses want 0", tag, fd);
    end
    if (total_out == FRAME_OUT) begin
      checks++;
      if (bus.frame_done !== 1'b1) begin
        errors++; $display("FAIL %s frame_done got %b want 1", tag, bus.frame_done);
      end
      drive_idle();
      @(posedge clk); #1;
      checks++;
      if (bus.frame_done !== 1'b0 || bus.valid_out !== 1'b0 || bus.ready_in !== 1'b1) begin
        errors++; $display("FAIL %s post_frame got fd=%b v=%b rdy=%b want fd=0 v=0 rdy=1",
                           tag, bus.frame_done, bus.valid_out, bus.ready_in);
      end
    end
  endtask

  task automatic test_ramp();
    apply_reset(1);
    run_frame(FRAME_OUT, 1'b0, 1'b0, 1'b0, "ramp");
  endtask

  task automatic test_backpressure();
    apply_reset(1);
    run_frame(FRAME_OUT, 1'b1, 1'b0, 1'b0, "backpressure");
  endtask

  task automatic test_ignored_valid();
    apply_reset(1);
    run_frame(FRAME_OUT, 1'b0, 1'b1, 1'b0, "ignored_valid");
  endtask

  task automatic test_mid_reset();
    apply_reset(1);
    // Four full row pairs, EMIT_A of the fifth, then part of its EMIT_B.
    run_frame(4 * 4 * HALF_WIDTH + 2 * HALF_WIDTH + 10, 1'b0, 1'b0, 1'b0, "pre_reset");
    bus.ready_out = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.valid_out !== 1'b0 || bus.ready_in !== 1'b1 || bus.frame_done !== 1'b0) begin
      errors++; $display("FAIL mid_reset got v=%b rdy=%b fd=%b want v=0 rdy=1 fd=0",
                         bus.valid_out, bus.ready_in, bus.frame_done);
    end
    rst_n = 1'b1;
    run_frame(FRAME_OUT, 1'b0, 1'b0, 1'b0, "post_reset");
  endtask

  task automatic test_channels();
    apply_reset(1);
    run_frame(FRAME_OUT, 1'b0, 1'b0, 1'b1, "channels");
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    @(posedge clk); #1;
    test_reset();
    test_latency();
    test_ramp();
    test_backpressure();
    test_ignored_valid();
    test_mid_reset();
    test_channels();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unpool_upsample_1.md
UNPOOL_UPSAMPLE_1 -- requirements
Module: unpool_upsample_1

Interface
REQ-001 Parameters (name, default, meaning): DATA_BIT, 12, per-channel sample width; HALF_WIDTH, 12, pooled frame width; HALF_HEIGHT, 12, pooled frame height; HALF_WIDTH_BIT, 4, column counter width.
REQ-002 Clock clk; reset rst_n, synchronous, active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 valid_in  in  1  upstream pooled sample valid.
REQ-006 ready_in  out  1  block accepts the upstream sample this cycle.
REQ-007 data_in_1, data_in_2, data_in_3  in  DATA_BIT each  unsigned pooled channel values (post-ReLU).
REQ-008 valid_out  out  1  upsampled sample valid.
REQ-009 ready_out  in  1  downstream accepts the sample this cycle.
REQ-010 data_out_1, data_out_2, data_out_3  out  DATA_BIT each  upsampled channel values, registered.
REQ-011 frame_done  out  1  one-cycle pulse after the last sample of a frame is accepted.

Function
REQ-012 The block SHALL perform 2x nearest-neighbour upsampling: input frame HALF_WIDTH x HALF_HEIGHT, raster order, to output frame 2*HALF_WIDTH x 2*HALF_HEIGHT (24x24, 576 samples), raster order.
REQ-013 Input transfer SHALL occur when valid_in && ready_in; output transfer SHALL occur when valid_out && ready_out.
REQ-014 FSM states SHALL be LOAD, EMIT_A, EMIT_B; reset state is LOAD.
REQ-015 LOAD: ready_in=1, valid_out=0; each transfer writes all three channels into row buffer[col_in], col_in increments; on transfer with col_in==HALF_WIDTH-1, col_in:=0 and state:=EMIT_A.
REQ-016 EMIT_A and EMIT_B: ready_in=0; output sample k (0..23) SHALL carry buffer[k>>1] for all three channels.
REQ-017 valid_out SHALL assert in the first cycle after entering EMIT_A (one-cycle latency after the 12th input transfer) and remain high across EMIT_A/EMIT_B until the 48th output transfer of the row pair.
REQ-018 While valid_out=1 and ready_out=0, data_out_* and valid_out SHALL hold stable.
REQ-019 Output column counter out_col (0..23) SHALL advance only on output transfer; at out_col==23 transfer it wraps to 0 and state advances EMIT_A->EMIT_B or EMIT_B->LOAD.
REQ-020 Leaving EMIT_B increments row_cnt; when row_cnt==HALF_HEIGHT-1 it wraps to 0 and frame_done pulses for exactly one cycle, in the cycle following the final transfer.
REQ-021 valid_in asserted while ready_in=0 SHALL be ignored; no buffer write and no counter change (upstream holds data).
REQ-022 Back-to-back: continuous ready_out=1 SHALL yield one output per cycle; throughput is 12 input cycles + 48 output cycles per input row.
REQ-023 No arithmetic on data; values pass bit-exact; output zero-extension or sign handling SHALL NOT occur.

Reset
REQ-024 On rst_n=0 at a clk edge: state:=LOAD, col_in, out_col, row_cnt:=0, valid_out:=0, frame_done:=0, data_out_*:=0; ready_in reads 1 the following cycle.
REQ-025 Reset mid-frame SHALL abandon the frame; the next accepted input is treated as row 0, column 0.
REQ-026 Row buffer contents SHALL NOT be reset.

Structure
REQ-027 DATA_BIT, HALF_WIDTH, HALF_HEIGHT, HALF_WIDTH_BIT and FSM state encodings SHALL reside in shared package cnn_pkg.
REQ-028 Row storage SHALL be one sub-module, upsample_line_buf (HALF_WIDTH x 3*DATA_BIT, one write port, one asynchronous read port); control FSM and counters in the top.

Verification
REQ-029 Ramp: input row r col c value 16*r+c on all channels, ready_out=1 -> output (y,x) equals 16*(y>>1)+(x>>1); 576 outputs; one frame_done pulse.
REQ-030 Latency: 12 inputs on consecutive cycles -> valid_out high in cycle 13 after first input, data_out = buffer[0].
REQ-031 Backpressure: ready_out toggling 1/0 with valid_out=1 -> no drop/duplication, data stable during ready_out=0, sequence identical to REQ-029.
REQ-032 valid_in held high during EMIT phases with changing data -> ready_in=0, buffer unchanged, outputs still match stored row.
REQ-033 Reset after 5 rows (mid EMIT_B) -> valid_out=0 next cycle, ready_in=1; a fresh 12x12 frame reproduces REQ-029 exactly.
REQ-034 Channel independence: channels fed 0xFFF, 0x000, 0x800 -> outputs 0xFFF, 0x000, 0x800 unchanged at every position.
